// File: rtl/alu_pkg.sv
// ============================================================================
// Module : alu_pkg
// Brief  : Shared ALU unit/op select codes and multiply-sequencer state type.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package alu_pkg;

  localparam logic [2:0] ALU_ADD      = 3'b000;
  localparam logic [2:0] ALU_AND      = 3'b001;
  localparam logic [2:0] ALU_SHIFT    = 3'b010;
  localparam logic [2:0] ALU_PASS_SRC = 3'b011;
  localparam logic [2:0] ALU_OR       = 3'b100;
  localparam logic [2:0] ALU_XOR      = 3'b101;
  localparam logic [2:0] ALU_PASS_ACC = 3'b111;

  localparam logic OP_LSHIFT = 1'b0;
  localparam logic OP_RSHIFT = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_SHL  = 2'd2,
    ST_DONE = 2'd3
  } mul_state_t;

endpackage

`default_nettype wire

// File: rtl/alu_mul_seq.sv
// ============================================================================
// Module : alu_mul_seq
// Brief  : Shift-and-add 8x8 (mod 256) multiplier sharing the core's ALU port.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int N_BITS     = 8,
  parameter int EARLY_EXIT = 1
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       start_in,
  input  logic [7:0] mcand_in,
  input  logic [7:0] mplier_in,
  output logic       busy_out,
  output logic       done_out,
  input  logic       ack_in,
  output logic [7:0] product_out,
  input  logic [2:0] core_unit_sel_in,
  input  logic       core_op_sel_in,
  input  logic [7:0] core_acc_in,
  input  logic [7:0] core_src_in,
  output logic       core_stall_out,
  output logic [2:0] alu_unit_sel_out,
  output logic       alu_op_sel_out,
  output logic [7:0] alu_acc_out,
  output logic [7:0] alu_src_out,
  input  logic [7:0] alu_res_in
);

  localparam logic [2:0] C_LAST_CNT = 3'(N_BITS - 1);

  mul_state_t r_state;
  mul_state_t w_next_state;
  logic [7:0] r_a;
  logic [7:0] r_b;
  logic [7:0] r_p;
  logic [2:0] r_cnt;
  logic [7:0] w_b_shr;

  assign w_b_shr = {1'b0, r_b[7:1]};

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state <= ST_IDLE;
      r_a     <= 8'd0;
      r_b     <= 8'd0;
      r_p     <= 8'd0;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        ST_IDLE: begin
          if (start_in) begin
            r_a   <= mcand_in;
            r_b   <= mplier_in;
            r_p   <= 8'd0;
            r_cnt <= 3'd0;
          end
        end
        ST_ADD: begin
          if (r_b[0]) r_p <= alu_res_in;
        end
        ST_SHL: begin
          r_a   <= alu_res_in;
          r_b   <= w_b_shr;
          r_cnt <= r_cnt + 3'd1;
        end
        default: ;
      endcase
    end
  end

  // The core owns the ALU in IDLE and DONE; the sequencer drives it only in ADD/SHL.
  always_comb begin
    w_next_state     = r_state;
    alu_unit_sel_out = core_unit_sel_in;
    alu_op_sel_out   = core_op_sel_in;
    alu_acc_out      = core_acc_in;
    alu_src_out      = core_src_in;
    case (r_state)
      ST_IDLE: begin
        if (start_in) begin
          if ((EARLY_EXIT != 0) && (mplier_in == 8'd0)) w_next_state = ST_DONE;
          else                                          w_next_state = ST_ADD;
        end
      end
      ST_ADD: begin
        w_next_state     = ST_SHL;
        alu_unit_sel_out = r_b[0] ? ALU_ADD : ALU_PASS_ACC;
        alu_op_sel_out   = 1'b0;
        alu_acc_out      = r_p;
        alu_src_out      = r_a;
      end
      ST_SHL: begin
        alu_unit_sel_out = ALU_SHIFT;
        alu_op_sel_out   = OP_LSHIFT;
        alu_acc_out      = r_a;
        alu_src_out      = 8'd1;
        if ((r_cnt == C_LAST_CNT) || ((EARLY_EXIT != 0) && (w_b_shr == 8'd0)))
          w_next_state = ST_DONE;
        else
          w_next_state = ST_ADD;
      end
      ST_DONE: begin
        if (ack_in) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  assign busy_out       = (r_state != ST_IDLE);
  assign done_out       = (r_state == ST_DONE);
  assign core_stall_out = (r_state == ST_ADD) || (r_state == ST_SHL);
  assign product_out    = r_p;

endmodule

`default_nettype wire

// File: tb/tb_alu_mul_seq.sv
// ============================================================================
// Module : tb_alu_mul_seq
// Brief  : Randomized self-checking bench with a behavioural ALU and product model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_alu_mul_seq;
  import alu_pkg::*;

  localparam int N_BITS     = 8;
  localparam int EARLY_EXIT = 1;

  logic       clk_in = 1'b0;
  logic       rst_n_in;
  logic       start_in;
  logic [7:0] mcand_in;
  logic [7:0] mplier_in;
  logic       busy_out;
  logic       done_out;
  logic       ack_in;
  logic [7:0] product_out;
  logic [2:0] core_unit_sel_in;
  logic       core_op_sel_in;
  logic [7:0] core_acc_in;
  logic [7:0] core_src_in;
  logic       core_stall_out;
  logic [2:0] alu_unit_sel_out;
  logic       alu_op_sel_out;
  logic [7:0] alu_acc_out;
  logic [7:0] alu_src_out;
  logic [7:0] alu_res_in;

  int n_checks = 0;
  int n_fail   = 0;

  alu_mul_seq #(.N_BITS(N_BITS), .EARLY_EXIT(EARLY_EXIT)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .start_in(start_in),
    .mcand_in(mcand_in), .mplier_in(mplier_in), .busy_out(busy_out),
    .done_out(done_out), .ack_in(ack_in), .product_out(product_out),
    .core_unit_sel_in(core_unit_sel_in), .core_op_sel_in(core_op_sel_in),
    .core_acc_in(core_acc_in), .core_src_in(core_src_in),
    .core_stall_out(core_stall_out), .alu_unit_sel_out(alu_unit_sel_out),
    .alu_op_sel_out(alu_op_sel_out), .alu_acc_out(alu_acc_out),
    .alu_src_out(alu_src_out), .alu_res_in(alu_res_in)
  );

  always #5 clk_in = ~clk_in;

  // Behavioural stand-in for the shared ALU.
  always_comb begin
    case (alu_unit_sel_out)
      ALU_ADD:      alu_res_in = alu_acc_out + alu_src_out;
      ALU_AND:      alu_res_in = alu_acc_out & alu_src_out;
      ALU_SHIFT:    alu_res_in = alu_op_sel_out ? (alu_acc_out >> alu_src_out[2:0])
                                                : (alu_acc_out << alu_src_out[2:0]);
      ALU_PASS_SRC: alu_res_in = alu_src_out;
      ALU_OR:       alu_res_in = alu_acc_out | alu_src_out;
      ALU_XOR:      alu_res_in = alu_acc_out ^ alu_src_out;
      ALU_PASS_ACC: alu_res_in = alu_acc_out;
      default:      alu_res_in = 8'd0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Bits iterated: up to the highest set multiplier bit with early exit, else all.
  function automatic int ref_bits(input logic [7:0] b);
    int k;
    k = 0;
    if (EARLY_EXIT == 0) return N_BITS;
    for (int i = 0; i < 8; i++) if (b[i]) k = i + 1;
    return (k > N_BITS) ? N_BITS : k;
  endfunction

  function automatic logic [7:0] ref_product(input logic [7:0] a, input logic [7:0] b);
    int unsigned full;
    full = (int'(a) * int'(b)) % 256;
    return full[7:0];
  endfunction

  // Called one delta after a rising edge with the DUT in IDLE.
  task automatic do_mul(input logic [7:0] a, input logic [7:0] b, input bit hold);
    int k, lat, stalls;
    logic [7:0] exp_p;
    k     = ref_bits(b);
    exp_p = ref_product(a, b);
    start_in  = 1'b1;
    mcand_in  = a;
    mplier_in = b;
    @(posedge clk_in); #1;
    start_in = 1'b0;
    core_unit_sel_in = ALU_XOR;
    core_acc_in      = 8'h5A;
    core_src_in      = 8'hC3;
    if (k > 0) begin
      check("add_unit", alu_unit_sel_out, b[0] ? ALU_ADD : ALU_PASS_ACC);
      check("add_acc", alu_acc_out, 8'd0);
      check("add_src", alu_src_out, a);
    end
    lat = 0;
    stalls = 0;
    while (!done_out && lat < 40) begin
      if (core_stall_out) stalls++;
      @(posedge clk_in); #1;
      lat++;
    end
    check("latency", lat, 2 * k);
    check("stall_cycles", stalls, 2 * k);
    check("done", done_out, 1'b1);
    check("product", product_out, exp_p);
    if (hold) begin
      repeat (5) begin
        start_in  = 1'b1;
        mcand_in  = 8'($urandom);
        mplier_in = 8'($urandom);
        @(posedge clk_in); #1;
        check("hold_done", done_out, 1'b1);
        check("hold_product", product_out, exp_p);
        check("hold_stall", core_stall_out, 1'b0);
      end
      start_in = 1'b0;
    end
    ack_in = 1'b1;
    @(posedge clk_in); #1;
    ack_in = 1'b0;
    check("idle_busy", busy_out, 1'b0);
    check("idle_done", done_out, 1'b0);
  endtask

  initial begin
    rst_n_in = 1'b0;
    start_in = 1'b0;
    ack_in = 1'b0;
    mcand_in = 8'd0;
    mplier_in = 8'd0;
    core_unit_sel_in = 3'd0;
    core_op_sel_in = 1'b0;
    core_acc_in = 8'd0;
    core_src_in = 8'd0;
    repeat (2) @(posedge clk_in);
    #1;
    check("rst_busy", busy_out, 1'b0);
    check("rst_done", done_out, 1'b0);
    check("rst_product", product_out, 8'd0);
    check("rst_stall", core_stall_out, 1'b0);
    rst_n_in = 1'b1;
    @(posedge clk_in); #1;

    core_unit_sel_in = ALU_XOR;
    core_op_sel_in   = 1'b0;
    core_acc_in      = 8'hA5;
    core_src_in      = 8'h0F;
    #1;
    check("pass_unit", alu_unit_sel_out, ALU_XOR);
    check("pass_res", alu_res_in, 8'hAA);

    do_mul(8'd3, 8'd5, 1'b0);
    do_mul(8'hFF, 8'hFF, 1'b0);
    do_mul(8'h10, 8'h10, 1'b0);
    do_mul(8'h37, 8'h00, 1'b0);
    do_mul(8'd9, 8'd11, 1'b1);
    do_mul(8'h81, 8'h80, 1'b0);

    for (int i = 0; i < 20; i++) begin
      core_unit_sel_in = 3'($urandom);
      core_op_sel_in   = 1'($urandom);
      core_acc_in      = 8'($urandom);
      core_src_in      = 8'($urandom);
      #1;
      check("rand_pass_acc", alu_acc_out, core_acc_in);
      @(posedge clk_in); #1;
      do_mul(8'($urandom), 8'($urandom), 1'b0);
    end

    // Abort partway through: accept, ADD, then drop reset during SHL.
    start_in  = 1'b1;
    mcand_in  = 8'd3;
    mplier_in = 8'd7;
    @(posedge clk_in); #1;
    start_in = 1'b0;
    @(posedge clk_in); #3;
    check("pre_rst_stall", core_stall_out, 1'b1);
    rst_n_in = 1'b0;
    #1;
    check("async_busy", busy_out, 1'b0);
    check("async_stall", core_stall_out, 1'b0);
    check("async_done", done_out, 1'b0);
    check("async_product", product_out, 8'd0);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    @(posedge clk_in); #1;
    check("post_rst_done", done_out, 1'b0);
    do_mul(8'd2, 8'd7, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
